cv32e40p_pdl_alarm_ctrl: RTL
============================

# cv32e40p_pdl_alarm_ctrl

Consumes the `alarm` output of the cv32e40p PDL clock-glitch detector and turns detector pulses into core actions. It qualifies alarm rising edges, runs a flush-request handshake with the core, and rate-limits flushes with a cooldown. It counts events, snapshots the `Q1`/`delay_line` taps, and raises a sticky lock when too many alarms fall inside a sliding window.

## Interface
Parameters:
- `CNT_W`, 8, width of the total alarm counter (saturating)
- `ESC_THRESH`, 3, strikes within the window that set lock (≥1)
- `WINDOW_CYCLES`, 64, strike window length in cycles (≥1)
- `COOLDOWN_CYCLES`, 16, minimum idle gap after a flush ack (≥1)

Ports:
- `clk`  in  1  core clock; single clock domain
- `rst_n`  in  1  reset, asynchronous, active-low
- `alarm`  in  1  raw alarm from the PDL detector
- `Q1`  in  1  PDL sampling-flop tap
- `delay_line`  in  1  PDL delay-line tap
- `flush_ack`  in  1  core accepts the flush request
- `clr`  in  1  single-cycle clear of counters, lock and snapshot
- `flush_req`  out  1  flush request to the core
- `lock`  out  1  sticky escalation flag
- `alarm_cnt`  out  CNT_W  total accepted alarms (saturating)
- `strikes`  out  $clog2(ESC_THRESH+1)  alarms in the current window
- `snap`  out  2  {Q1, delay_line} captured at the last accepted alarm
- `state`  out  2  FSM state: 0 IDLE, 1 FLUSH, 2 COOL

## Operation
- Accepted alarm: `alarm` is high at a posedge and was low at the previous posedge. The edge register resets to 0, so an alarm held high counts once.
- On every accepted alarm, in any state:
  - `alarm_cnt` increments, saturating at 2^CNT_W−1.
  - `snap` loads {Q1, delay_line}.
  - `strikes` increments, saturating at ESC_THRESH.
  - The window counter reloads WINDOW_CYCLES−1.
- Window counter: decrements each cycle while `strikes` > 0. If it is at 0 and no alarm is accepted that cycle, `strikes` clears. If an alarm coincides with expiry, the alarm wins (`strikes` increments, window reloads).
- `lock` sets on the edge where `strikes` reaches ESC_THRESH. It stays set until `clr` or reset. `lock` never gates flushing.
- FSM:
  - IDLE: an accepted alarm moves to FLUSH.
  - FLUSH: `flush_req`=1 and is held until `flush_ack` is sampled high. Then move to COOL and load the cooldown counter with COOLDOWN_CYCLES−1.
  - COOL: decrement the counter. At 0, move to FLUSH if `pending` is set (and clear `pending`), otherwise to IDLE.
- An accepted alarm in FLUSH or COOL sets a one-deep `pending` flag. Further alarms are counted but not queued.
- `flush_ack` outside FLUSH is ignored.
- `clr` clears `alarm_cnt`, `strikes`, the window counter, `lock`, `snap` and `pending`. It does not abort FLUSH or COOL. If `clr` and an accepted alarm occur in the same cycle, the clear applies first, then the alarm: `alarm_cnt`=1, `strikes`=1, `pending` set only if not in IDLE.

## Timing
- Reset values: `flush_req`=0, `lock`=0, `alarm_cnt`=0, `strikes`=0, `snap`=0, `state`=IDLE. Internal edge register, `pending`, window and cooldown counters are all 0.
- All outputs are registered.
- Alarm sampled at edge N (macro off): `flush_req`, `alarm_cnt`, `strikes` and `snap` are updated after edge N.
- `flush_ack` high at edge M: `flush_req`=0 and `state`=COOL after edge M. The earliest next `flush_req` is after edge M+COOLDOWN_CYCLES.
- A combinational ack-to-req path is forbidden.

## Configuration
- `CV32E40P_PDL_ALARM_SYNC_EN` defined:
  - A 2-flop synchronizer (reset 0) is placed on `alarm`, ahead of edge detection.
  - `Q1` and `delay_line` pass through matching 2-flop stages, so `snap` stays aligned with the alarm.
  - All alarm-to-output latencies grow by 2 cycles.
- Undefined: `alarm`, `Q1` and `delay_line` are sampled directly.

## Test plan
- Reset release, single 1-cycle `alarm` at edge 5, `flush_ack` at edge 8:
  - `flush_req` is high after edge 5 through edge 8.
  - `alarm_cnt`=1, `strikes`=1.
  - IDLE after edge 8+16.
- `alarm` held high for 20 cycles → `alarm_cnt`=1, exactly one flush.
- Three alarms 10 cycles apart (ESC_THRESH=3) → `lock`=1 after the third; `strikes`=3. Two alarms 70 cycles apart → `strikes` returns to 0 before the second; `lock`=0.
- Two alarms during COOL, `flush_ack` immediate → exactly one extra flush issued when COOL ends; `alarm_cnt`=3.
- `clr` coincident with an alarm while `lock`=1 and `alarm_cnt`=5 → `lock`=0, `alarm_cnt`=1, `strikes`=1.
- Macro defined: alarm at edge 5 → `flush_req` after edge 7; `snap` equals {Q1, delay_line} driven at edge 5.

Source files
------------

// File: rtl/cv32e40p_pdl_alarm_ctrl.sv
// cv32e40p_pdl_alarm_ctrl
// Turns PDL clock-glitch detector alarm pulses into core flush requests.
// Alarm rising edges are qualified and counted. The {Q1, delay_line} taps are
// snapshotted on each accepted alarm. Flushes are rate-limited by a cooldown,
// with a one-deep pending flag for alarms that arrive while a flush is busy.
// A sliding strike window raises a sticky lock.
// Optional feature macro: CV32E40P_PDL_ALARM_SYNC_EN adds 2-flop synchronizers
// on alarm, Q1 and delay_line. This adds 2 cycles to every alarm-to-output path.
module cv32e40p_pdl_alarm_ctrl #(
    parameter int CNT_W           = 8,
    parameter int ESC_THRESH      = 3,
    parameter int WINDOW_CYCLES   = 64,
    parameter int COOLDOWN_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              alarm,
    input  logic                              Q1,
    input  logic                              delay_line,
    input  logic                              flush_ack,
    input  logic                              clr,
    output logic                              flush_req,
    output logic                              lock,
    output logic [CNT_W-1:0]                  alarm_cnt,
    output logic [$clog2(ESC_THRESH+1)-1:0]   strikes,
    output logic [1:0]                        snap,
    output logic [1:0]                        state
);

    localparam int STR_W  = $clog2(ESC_THRESH + 1);
    localparam int WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int COOL_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

    localparam logic [STR_W-1:0]  STR_MAX   = STR_W'(ESC_THRESH);
    localparam logic [WIN_W-1:0]  WIN_LOAD  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_COOL  = 2'd2
    } state_e;

    // Saturating increment of the total alarm counter
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Saturating increment of the strike counter (caps at ESC_THRESH)
    function automatic logic [STR_W-1:0] str_sat_inc(input logic [STR_W-1:0] v);
        if (v >= STR_MAX) begin
            return STR_MAX;
        end else begin
            return v + STR_W'(1);
        end
    endfunction

    logic alarm_s, q1_s, dl_s, accept_s;

`ifdef CV32E40P_PDL_ALARM_SYNC_EN
    logic [1:0] alarm_sync_r, q1_sync_r, dl_sync_r;

    // Two-flop stages on alarm and both taps, so the snapshot stays aligned with the alarm
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_sync_r <= 2'b00;
            q1_sync_r    <= 2'b00;
            dl_sync_r    <= 2'b00;
        end else begin
            alarm_sync_r <= {alarm_sync_r[0], alarm};
            q1_sync_r    <= {q1_sync_r[0], Q1};
            dl_sync_r    <= {dl_sync_r[0], delay_line};
        end
    end

    assign alarm_s = alarm_sync_r[1];
    assign q1_s    = q1_sync_r[1];
    assign dl_s    = dl_sync_r[1];
`else
    assign alarm_s = alarm;
    assign q1_s    = Q1;
    assign dl_s    = delay_line;
`endif

    logic               alarm_d_r;
    logic [CNT_W-1:0]   cnt_r, cnt_n_s;
    logic [STR_W-1:0]   str_r, str_n_s, str_base_s;
    logic [WIN_W-1:0]   win_r, win_n_s, win_base_s;
    logic [COOL_W-1:0]  cool_r, cool_n_s;
    logic [1:0]         snap_r, snap_n_s;
    logic               lock_r, lock_n_s;
    logic               pend_r, pend_n_s;
    logic               flush_req_r, flush_req_n_s;
    state_e             state_r, state_n_s;

    // A held-high alarm is accepted only on its first sampled cycle
    assign accept_s = alarm_s & ~alarm_d_r;

    // Counter, snapshot, strike window and lock: clear is applied first, then the alarm
    always_comb begin
        cnt_n_s    = clr ? {CNT_W{1'b0}} : cnt_r;
        snap_n_s   = clr ? 2'b00 : snap_r;
        lock_n_s   = clr ? 1'b0 : lock_r;
        str_base_s = clr ? {STR_W{1'b0}} : str_r;
        win_base_s = clr ? {WIN_W{1'b0}} : win_r;
        str_n_s    = str_base_s;
        win_n_s    = win_base_s;
        if (accept_s) begin
            cnt_n_s  = cnt_sat_inc(cnt_n_s);
            snap_n_s = {q1_s, dl_s};
            str_n_s  = str_sat_inc(str_base_s);
            win_n_s  = WIN_LOAD;
        end else if (str_base_s != {STR_W{1'b0}}) begin
            if (win_base_s == {WIN_W{1'b0}}) begin
                str_n_s = {STR_W{1'b0}};
                win_n_s = {WIN_W{1'b0}};
            end else begin
                str_n_s = str_base_s;
                win_n_s = win_base_s - WIN_W'(1);
            end
        end else begin
            str_n_s = str_base_s;
            win_n_s = win_base_s;
        end
        if (accept_s && (str_n_s == STR_MAX)) begin
            lock_n_s = 1'b1;
        end else begin
            lock_n_s = lock_n_s;
        end
    end

    // Flush handshake FSM with cooldown and one-deep pending alarm
    always_comb begin
        state_n_s = state_r;
        cool_n_s  = cool_r;
        pend_n_s  = clr ? 1'b0 : pend_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_n_s = ST_FLUSH;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_ack) begin
                    state_n_s = ST_COOL;
                    cool_n_s  = COOL_LOAD;
                end else begin
                    state_n_s = ST_FLUSH;
                end
            end
            ST_COOL: begin
                if (cool_r == {COOL_W{1'b0}}) begin
                    if (pend_n_s) begin
                        state_n_s = ST_FLUSH;
                        pend_n_s  = 1'b0;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end else begin
                    cool_n_s = cool_r - COOL_W'(1);
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                cool_n_s  = {COOL_W{1'b0}};
            end
        endcase
        if (accept_s && (state_r != ST_IDLE)) begin
            pend_n_s = 1'b1;
        end else begin
            pend_n_s = pend_n_s;
        end
        flush_req_n_s = (state_n_s == ST_FLUSH);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_d_r   <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            str_r       <= {STR_W{1'b0}};
            win_r       <= {WIN_W{1'b0}};
            cool_r      <= {COOL_W{1'b0}};
            snap_r      <= 2'b00;
            lock_r      <= 1'b0;
            pend_r      <= 1'b0;
            flush_req_r <= 1'b0;
            state_r     <= ST_IDLE;
        end else begin
            alarm_d_r   <= alarm_s;
            cnt_r       <= cnt_n_s;
            str_r       <= str_n_s;
            win_r       <= win_n_s;
            cool_r      <= cool_n_s;
            snap_r      <= snap_n_s;
            lock_r      <= lock_n_s;
            pend_r      <= pend_n_s;
            flush_req_r <= flush_req_n_s;
            state_r     <= state_n_s;
        end
    end

    assign flush_req = flush_req_r;
    assign lock      = lock_r;
    assign alarm_cnt = cnt_r;
    assign strikes   = str_r;
    assign snap      = snap_r;
    assign state     = state_r;

endmodule
